sig_pid_ctrl: RTL and testbench
===============================

SIG_PID_CTRL -- requirements
Module: sig_pid_ctrl

Parameters
REQ-001 SHALL have parameter ADC_W, default 8: width of the sample and setpoint inputs.
REQ-002 SHALL have parameter OUT_W, default 20: control word width.
REQ-003 SHALL have parameter COEF_W, default 8: unsigned gain width.
REQ-004 SHALL have parameter FRAC, default 4: right-shift applied to the PID sum.
REQ-005 SHALL have parameter INT_W, default OUT_W+4: signed integrator width.
REQ-006 SHALL have parameter LOCK_TOL, default 2: lock error tolerance in LSB.
REQ-007 SHALL have parameter LOCK_CNT, default 16: consecutive in-tolerance samples needed to lock.
REQ-008 SHALL have parameter TIMEOUT, default 1024: handshake timeout in clocks.

Interface
REQ-009 SHALL have port clk_core, in, 1: single clock; all logic on its rising edge.
REQ-010 SHALL have port rstn, in, 1: reset, asynchronous, active-low.
REQ-011 SHALL have port pid_en, in, 1: loop enable.
REQ-012 SHALL have port Vin, in, ADC_W: ADC sample, unsigned.
REQ-013 SHALL have port vin_valid, in, 1: one-cycle strobe marking Vin valid.
REQ-014 SHALL have port setpoint, in, ADC_W: target value, unsigned.
REQ-015 SHALL have ports kp, ki and kd, in, COEF_W each: gains, unsigned.
REQ-016 SHALL have port controlword_hex, out, OUT_W: saturated control word.
REQ-017 SHALL have port data_en, out, 1: new-word request to the transmitter.
REQ-018 SHALL have port rx_finish, in, 1: transmitter acknowledge.
REQ-019 SHALL have port DIR, out, 1: 1 when the last word is >= the previous word.
REQ-020 SHALL have port locked, out, 1: loop stable indicator.
REQ-021 SHALL have port tx_timeout, out, 1: sticky handshake timeout flag.

Function
REQ-022 SHALL implement FSM states IDLE, ERR, MAC, SAT and SEND.
REQ-023 SHALL, in IDLE with vin_valid=1 and pid_en=1, capture Vin and go to ERR; vin_valid in any other state or with pid_en=0 is ignored.
REQ-024 SHALL, in ERR, compute e = setpoint - Vin (signed, ADC_W+1 bits), de = e - e_prev, and integ = clamp(integ + e, ±(2^(INT_W-1)-1)); update e_prev = e; go to MAC.
REQ-025 SHALL, in MAC, compute sum = kp*e + ki*integ + kd*de at full signed width (no intermediate truncation), then u = sum >>> FRAC (arithmetic); go to SAT.
REQ-026 SHALL, in SAT, saturate u to [0, 2^OUT_W-1]; set DIR = (new >= controlword_hex); load controlword_hex; update the lock logic; go to SEND.
REQ-027 SHALL, in SEND, hold data_en=1 until rx_finish=1 is sampled; then drop data_en on the next clock and return to IDLE.
REQ-028 SHALL, if rx_finish is not seen within TIMEOUT clocks of entering SEND, drop data_en, set tx_timeout, and return to IDLE; tx_timeout is cleared only by reset.
REQ-029 SHALL ignore rx_finish outside SEND.
REQ-030 SHALL, per computed sample, increment a lock counter (saturating at LOCK_CNT) when |e| <= LOCK_TOL, otherwise clear the counter and locked; locked=1 when the counter = LOCK_CNT.
REQ-031 SHALL, while pid_en=0, clear integ, e_prev, the lock counter and locked, hold controlword_hex, and let any in-progress sequence finish.
REQ-032 SHALL hold latency from vin_valid to data_en rise at exactly 4 clocks.

Reset
REQ-033 SHALL, on rstn=0 at any time including mid-SEND, immediately force FSM=IDLE, data_en=0, controlword_hex=0, DIR=0, locked=0, tx_timeout=0, integ=0, e_prev=0, lock counter=0 and timeout counter=0.

Verification
REQ-034 SHALL verify proportional action: defaults, kp=16, ki=0, kd=0, setpoint=100, Vin=90 -> controlword_hex=10, DIR=1, data_en 4 clocks after the strobe.
REQ-035 SHALL verify integral action: kp=0, ki=16, kd=0, e=10 on three samples, each acknowledged -> words 10, 20, 30.
REQ-036 SHALL verify saturation: kp=16, setpoint=0, Vin=200 -> controlword_hex=0, DIR=0; kp=255, ki=255, with many samples at e=255 -> word clamps at 0xFFFFF and never wraps.
REQ-037 SHALL verify lock: setpoint=Vin=128 for 16 acknowledged samples -> locked rises after the 16th; one sample at Vin=131 -> locked=0.
REQ-038 SHALL verify timeout: rx_finish held low -> data_en falls after 1024 clocks and tx_timeout=1; the next strobe is still processed.
REQ-039 SHALL verify reset mid-operation: rstn pulsed low during SEND -> all outputs 0 immediately; a vin_valid arriving during SEND is ignored.

Source files
------------

// File: rtl/sig_pid_ctrl.sv
// sig_pid_ctrl: sampled PID loop with a saturated control word and a request/acknowledge
// handshake to a downstream transmitter.
//
// Ports
//   clk_core        : single clock, rising edge
//   rstn            : asynchronous active-low reset
//   pid_en          : loop enable; while low the loop memory (integrator, previous error,
//                     lock state) is cleared and no new sample is accepted
//   Vin / vin_valid : unsigned ADC sample and its one-cycle strobe
//   setpoint        : unsigned target value
//   kp / ki / kd    : unsigned gains
//   controlword_hex : saturated control word, range [0, 2^OUT_W-1]
//   data_en         : new-word request, held until rx_finish or timeout
//   rx_finish       : transmitter acknowledge, only looked at while a request is pending
//   DIR             : 1 when the latest word is >= the previous word
//   locked          : LOCK_CNT consecutive samples had |error| <= LOCK_TOL
//   tx_timeout      : sticky; set when a request went unacknowledged for TIMEOUT clocks
module sig_pid_ctrl #(
  parameter int ADC_W    = 8,
  parameter int OUT_W    = 20,
  parameter int COEF_W   = 8,
  parameter int FRAC     = 4,
  parameter int INT_W    = OUT_W + 4,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk_core,
  input  logic              rstn,
  input  logic              pid_en,
  input  logic [ADC_W-1:0]  Vin,
  input  logic              vin_valid,
  input  logic [ADC_W-1:0]  setpoint,
  input  logic [COEF_W-1:0] kp,
  input  logic [COEF_W-1:0] ki,
  input  logic [COEF_W-1:0] kd,
  output logic [OUT_W-1:0]  controlword_hex,
  output logic              data_en,
  input  logic              rx_finish,
  output logic              DIR,
  output logic              locked,
  output logic              tx_timeout
);

  // Full-precision accumulator: largest product is a gain times the integrator,
  // plus headroom for the three-term sum and the sign bit.
  localparam int SUM_W = COEF_W + INT_W + 3;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int LCK_W = $clog2(LOCK_CNT + 1);

  localparam logic signed [INT_W:0] INT_MAX = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W:0] INT_MIN = -INT_MAX;

  typedef enum logic [2:0] {IDLE, ERR, MAC, SAT, SEND} state_t;

  state_t                    state_reg, state_next;
  logic [ADC_W-1:0]          vin_reg;
  logic signed [ADC_W:0]     e_reg, e_prev_reg, e_next;
  logic signed [ADC_W+1:0]   de_reg, de_next;
  logic signed [INT_W-1:0]   integ_reg, integ_clamp;
  logic signed [INT_W:0]     integ_sum;
  logic signed [SUM_W-1:0]   u_reg, u_next, sum;
  logic [OUT_W-1:0]          cw_reg, sat_word;
  logic                      dir_reg, locked_reg, data_en_reg, tx_timeout_reg;
  logic [LCK_W-1:0]          lock_cnt_reg, lock_cnt_next;
  logic [TMO_W-1:0]          tmo_cnt_reg;
  logic                      tmo_hit, in_tol;
  logic [ADC_W:0]            abs_e;

  logic signed [SUM_W-1:0]   gain_x [3];
  logic signed [SUM_W-1:0]   op_x   [3];
  logic signed [SUM_W-1:0]   prod   [3];

  // ---------------- error / integrator ----------------
  assign e_next    = $signed({1'b0, setpoint}) - $signed({1'b0, vin_reg});
  assign de_next   = {e_next[ADC_W], e_next} - {e_prev_reg[ADC_W], e_prev_reg};
  assign integ_sum = {integ_reg[INT_W-1], integ_reg}
                   + {{(INT_W-ADC_W){e_next[ADC_W]}}, e_next};

  always_comb begin
    integ_clamp = integ_sum[INT_W-1:0];
    if (integ_sum > INT_MAX)      integ_clamp = INT_MAX[INT_W-1:0];
    else if (integ_sum < INT_MIN) integ_clamp = INT_MIN[INT_W-1:0];
  end

  // ---------------- multiply-accumulate ----------------
  // Gains are unsigned, so they are zero-extended; operands are sign-extended.
  assign gain_x[0] = {{(SUM_W-COEF_W){1'b0}}, kp};
  assign gain_x[1] = {{(SUM_W-COEF_W){1'b0}}, ki};
  assign gain_x[2] = {{(SUM_W-COEF_W){1'b0}}, kd};
  assign op_x[0]   = {{(SUM_W-ADC_W-1){e_reg[ADC_W]}}, e_reg};
  assign op_x[1]   = {{(SUM_W-INT_W){integ_reg[INT_W-1]}}, integ_reg};
  assign op_x[2]   = {{(SUM_W-ADC_W-2){de_reg[ADC_W+1]}}, de_reg};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_term
      assign prod[gi] = gain_x[gi] * op_x[gi];
    end
  endgenerate

  assign sum    = prod[0] + prod[1] + prod[2];
  assign u_next = sum >>> FRAC;

  // ---------------- saturation / lock ----------------
  always_comb begin
    sat_word = u_reg[OUT_W-1:0];
    if (u_reg[SUM_W-1])               sat_word = '0;
    else if (|u_reg[SUM_W-2:OUT_W])   sat_word = '1;
  end

  assign abs_e  = e_reg[ADC_W] ? (-e_reg) : e_reg;
  assign in_tol = (abs_e <= (ADC_W+1)'(LOCK_TOL));

  always_comb begin
    lock_cnt_next = '0;
    if (in_tol) begin
      lock_cnt_next = (lock_cnt_reg == LCK_W'(LOCK_CNT)) ? lock_cnt_reg : lock_cnt_reg + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (vin_valid && pid_en) state_next = ERR;
      ERR:     state_next = MAC;
      MAC:     state_next = SAT;
      SAT:     state_next = SEND;
      SEND:    if (rx_finish || tmo_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      vin_reg        <= '0;
      e_reg          <= '0;
      e_prev_reg     <= '0;
      de_reg         <= '0;
      integ_reg      <= '0;
      u_reg          <= '0;
      cw_reg         <= '0;
      dir_reg        <= 1'b0;
      lock_cnt_reg   <= '0;
      locked_reg     <= 1'b0;
      data_en_reg    <= 1'b0;
      tx_timeout_reg <= 1'b0;
      tmo_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE && vin_valid && pid_en) vin_reg <= Vin;

      if (state_reg == ERR) begin
        e_reg  <= e_next;
        de_reg <= de_next;
      end

      // Loop memory is cleared whenever the loop is disabled; a sample already
      // in flight still runs to completion and loads its word.
      if (!pid_en) begin
        integ_reg  <= '0;
        e_prev_reg <= '0;
      end else if (state_reg == ERR) begin
        integ_reg  <= integ_clamp;
        e_prev_reg <= e_next;
      end

      if (state_reg == MAC) u_reg <= u_next;

      if (state_reg == SAT) begin
        dir_reg     <= (sat_word >= cw_reg);
        cw_reg      <= sat_word;
        data_en_reg <= 1'b1;
        tmo_cnt_reg <= '0;
      end

      if (!pid_en) begin
        lock_cnt_reg <= '0;
        locked_reg   <= 1'b0;
      end else if (state_reg == SAT) begin
        lock_cnt_reg <= lock_cnt_next;
        locked_reg   <= (lock_cnt_next == LCK_W'(LOCK_CNT));
      end

      // Acknowledge wins over a timeout expiring on the same clock.
      if (state_reg == SEND) begin
        if (rx_finish) begin
          data_en_reg <= 1'b0;
        end else if (tmo_hit) begin
          data_en_reg    <= 1'b0;
          tx_timeout_reg <= 1'b1;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign controlword_hex = cw_reg;
  assign data_en         = data_en_reg;
  assign DIR             = dir_reg;
  assign locked          = locked_reg;
  assign tx_timeout      = tx_timeout_reg;

endmodule

// File: tb/tb_sig_pid_ctrl.sv
// tb_sig_pid_ctrl: directed-vector bench for sig_pid_ctrl with default parameters.
module tb_sig_pid_ctrl;

  logic        clk_core = 1'b0;
  logic        rstn = 1'b0;
  logic        pid_en = 1'b0;
  logic [7:0]  Vin = '0;
  logic        vin_valid = 1'b0;
  logic [7:0]  setpoint = '0;
  logic [7:0]  kp = '0, ki = '0, kd = '0;
  logic [19:0] controlword_hex;
  logic        data_en;
  logic        rx_finish = 1'b0;
  logic        DIR;
  logic        locked;
  logic        tx_timeout;

  int vec_cnt = 0;
  int err_cnt = 0;

  sig_pid_ctrl dut (
    .clk_core        (clk_core),
    .rstn            (rstn),
    .pid_en          (pid_en),
    .Vin             (Vin),
    .vin_valid       (vin_valid),
    .setpoint        (setpoint),
    .kp              (kp),
    .ki              (ki),
    .kd              (kd),
    .controlword_hex (controlword_hex),
    .data_en         (data_en),
    .rx_finish       (rx_finish),
    .DIR             (DIR),
    .locked          (locked),
    .tx_timeout      (tx_timeout)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  task automatic apply_reset;
    rstn = 1'b0; vin_valid = 1'b0; rx_finish = 1'b0;
    tick; tick;
    rstn = 1'b1;
    pid_en = 1'b1;
  endtask

  // Strobe one sample, wait (bounded) for data_en, optionally acknowledge.
  // lat counts clocks from the strobe edge to the first clock where data_en is high.
  task automatic do_sample(input logic [7:0] v, input bit ack, output int lat);
    Vin = v; vin_valid = 1'b1;
    tick;
    vin_valid = 1'b0;
    lat = 1;
    while (data_en !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    if (ack) begin
      rx_finish = 1'b1;
      tick;
      rx_finish = 1'b0;
    end
  endtask

  task automatic test_reset;
    apply_reset;
    vec_cnt++;
    if ({controlword_hex, data_en, DIR, locked, tx_timeout} !== 24'h0) begin
      err_cnt++;
      $display("FAIL reset_state: got cw=%h de=%b dir=%b lk=%b to=%b, want all 0",
               controlword_hex, data_en, DIR, locked, tx_timeout);
    end
  endtask

  task automatic test_proportional;
    int lat;
    apply_reset;
    kp = 8'd16; ki = 8'd0; kd = 8'd0; setpoint = 8'd100;
    do_sample(8'd90, 1'b0, lat);
    vec_cnt++;
    if (lat !== 4) begin err_cnt++; $display("FAIL prop_latency: got %0d want 4", lat); end
    vec_cnt++;
    if (controlword_hex !== 20'd10) begin
      err_cnt++; $display("FAIL prop_word: got %0d want 10", controlword_hex);
    end
    vec_cnt++;
    if (DIR !== 1'b1) begin err_cnt++; $display("FAIL prop_dir: got %b want 1", DIR); end
    rx_finish = 1'b1; tick; rx_finish = 1'b0;
    vec_cnt++;
    if (data_en !== 1'b0) begin err_cnt++; $display("FAIL prop_ack_drop: got %b want 0", data_en); end
  endtask

  // Runs directly after test_proportional so the previous word is 10.
  task automatic test_sat_low;
    int lat;
    kp = 8'd16; setpoint = 8'd0;
    do_sample(8'd200, 1'b1, lat);
    vec_cnt++;
    if (controlword_hex !== 20'd0) begin
      err_cnt++; $display("FAIL sat_low_word: got %0d want 0", controlword_hex);
    end
    vec_cnt++;
    if (DIR !== 1'b0) begin err_cnt++; $display("FAIL sat_low_dir: got %b want 0", DIR); end
  endtask

  task automatic test_integral;
    int lat;
    logic [19:0] exp_w;
    apply_reset;
    kp = 8'd0; ki = 8'd16; kd = 8'd0; setpoint = 8'd100;
    for (int k = 1; k <= 3; k++) begin
      do_sample(8'd90, 1'b1, lat);
      exp_w = 20'(10 * k);
      vec_cnt++;
      if (controlword_hex !== exp_w) begin
        err_cnt++; $display("FAIL integ_word_%0d: got %0d want %0d", k, controlword_hex, exp_w);
      end
    end
  endtask

  // e=255 every sample: sum_k = 255*255 + 255*(255*k) = 65025*(k+1), word = sum>>4, clamped.
  task automatic test_sat_high;
    int lat;
    longint exp_l;
    logic [19:0] exp_w;
    apply_reset;
    kp = 8'd255; ki = 8'd255; kd = 8'd0; setpoint = 8'd255;
    for (int k = 1; k <= 300; k++) begin
      do_sample(8'd0, 1'b1, lat);
      exp_l = (longint'(65025) * (k + 1)) >> 4;
      if (exp_l > 64'hFFFFF) exp_l = 64'hFFFFF;
      exp_w = exp_l[19:0];
      vec_cnt++;
      if (controlword_hex !== exp_w) begin
        err_cnt++; $display("FAIL sat_high_word_%0d: got %h want %h", k, controlword_hex, exp_w);
      end
    end
    vec_cnt++;
    if (DIR !== 1'b1) begin err_cnt++; $display("FAIL sat_high_dir: got %b want 1", DIR); end
  endtask

  task automatic test_lock;
    int lat;
    logic exp_lk;
    apply_reset;
    kp = 8'd16; ki = 8'd0; kd = 8'd0; setpoint = 8'd128;
    for (int k = 1; k <= 16; k++) begin
      do_sample(8'd128, 1'b1, lat);
      exp_lk = (k == 16);
      vec_cnt++;
      if (locked !== exp_lk) begin
        err_cnt++; $display("FAIL lock_sample_%0d: got %b want %b", k, locked, exp_lk);
      end
    end
    do_sample(8'd131, 1'b1, lat);
    vec_cnt++;
    if (locked !== 1'b0) begin err_cnt++; $display("FAIL lock_lost: got %b want 0", locked); end
  endtask

  task automatic test_timeout;
    int lat;
    apply_reset;
    kp = 8'd16; ki = 8'd0; kd = 8'd0; setpoint = 8'd100;
    do_sample(8'd90, 1'b0, lat);
    repeat (1023) tick;
    vec_cnt++;
    if (data_en !== 1'b1 || tx_timeout !== 1'b0) begin
      err_cnt++; $display("FAIL tmo_before: got de=%b to=%b want de=1 to=0", data_en, tx_timeout);
    end
    tick;
    vec_cnt++;
    if (data_en !== 1'b0 || tx_timeout !== 1'b1) begin
      err_cnt++; $display("FAIL tmo_expire: got de=%b to=%b want de=0 to=1", data_en, tx_timeout);
    end
    do_sample(8'd80, 1'b1, lat);
    vec_cnt++;
    if (lat !== 4 || controlword_hex !== 20'd20 || tx_timeout !== 1'b1) begin
      err_cnt++; $display("FAIL tmo_next_sample: got lat=%0d cw=%0d to=%b want lat=4 cw=20 to=1",
                          lat, controlword_hex, tx_timeout);
    end
  endtask

  task automatic test_ignore_when_disabled;
    bit seen;
    apply_reset;
    kp = 8'd16; ki = 8'd0; kd = 8'd0; setpoint = 8'd100;
    pid_en = 1'b0;
    Vin = 8'd90; vin_valid = 1'b1; tick; vin_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick; if (data_en === 1'b1) seen = 1'b1; end
    vec_cnt++;
    if (seen !== 1'b0) begin err_cnt++; $display("FAIL disabled_strobe: got request=%b want 0", seen); end
    pid_en = 1'b1;
  endtask

  task automatic test_reset_mid_send;
    int lat;
    bit seen;
    apply_reset;
    kp = 8'd16; ki = 8'd0; kd = 8'd0; setpoint = 8'd100;
    do_sample(8'd90, 1'b0, lat);
    // strobe during SEND must be dropped
    Vin = 8'd50; vin_valid = 1'b1; tick; vin_valid = 1'b0;
    rx_finish = 1'b1; tick; rx_finish = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick; if (data_en === 1'b1) seen = 1'b1; end
    vec_cnt++;
    if (seen !== 1'b0 || controlword_hex !== 20'd10) begin
      err_cnt++; $display("FAIL send_strobe_ignored: got request=%b cw=%0d want 0 and 10",
                          seen, controlword_hex);
    end
    do_sample(8'd90, 1'b0, lat);
    #2 rstn = 1'b0;
    #1;
    vec_cnt++;
    if ({controlword_hex, data_en, DIR, locked, tx_timeout} !== 24'h0) begin
      err_cnt++;
      $display("FAIL async_reset: got cw=%h de=%b dir=%b lk=%b to=%b, want all 0",
               controlword_hex, data_en, DIR, locked, tx_timeout);
    end
    tick; rstn = 1'b1;
    seen = 1'b0;
    repeat (4) begin tick; if (data_en === 1'b1) seen = 1'b1; end
    vec_cnt++;
    if (seen !== 1'b0) begin err_cnt++; $display("FAIL post_reset_idle: got request=%b want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_proportional;
    test_sat_low;
    test_integral;
    test_sat_high;
    test_lock;
    test_timeout;
    test_ignore_when_disabled;
    test_reset_mid_send;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
